// File: rtl/snake_pkg.sv
// Shared types and coordinate helpers for the snake body controller.
// A coordinate is {x[6:0], y[6:0]}, i.e. value = x*128 + y.
package snake_pkg;

   localparam int COORD_W = 14;
   localparam int X_W     = 7;
   localparam int Y_W     = 7;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      CALC,
      SCAN,
      MOVE,
      POP,
      DONE,
      DEAD
   } state_e;

   function automatic logic [COORD_W-1:0] coord_pack(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
      return {x, y};
   endfunction

   function automatic logic [X_W-1:0] coord_x(input logic [COORD_W-1:0] c);
      return c[COORD_W-1 -: X_W];
   endfunction

   function automatic logic [Y_W-1:0] coord_y(input logic [COORD_W-1:0] c);
      return c[Y_W-1:0];
   endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculation with wall detection.
// A move that would leave the grid flags wall_hit_o; next_o is then don't-care.
module snake_next_head
   import snake_pkg::*;
#(
   parameter int GRID_W = 80,
   parameter int GRID_H = 60
) (
   input  logic [COORD_W-1:0] head_i,
   input  logic [1:0]         heading_i,
   output logic [COORD_W-1:0] next_o,
   output logic               wall_hit_o
);

   logic [X_W-1:0] x;
   logic [X_W-1:0] nx;
   logic [Y_W-1:0] y;
   logic [Y_W-1:0] ny;

   always_comb begin
      x          = coord_x(head_i);
      y          = coord_y(head_i);
      nx         = x;
      ny         = y;
      wall_hit_o = 1'b0;
      case (heading_i)
         DIR_UP: begin
            wall_hit_o = (y == '0);
            ny         = y - 1'b1;
         end
         DIR_RIGHT: begin
            wall_hit_o = (x == X_W'(GRID_W - 1));
            nx         = x + 1'b1;
         end
         DIR_DOWN: begin
            wall_hit_o = (y == Y_W'(GRID_H - 1));
            ny         = y + 1'b1;
         end
         default: begin
            wall_hit_o = (x == '0);
            nx         = x - 1'b1;
         end
      endcase
      next_o = coord_pack(nx, ny);
   end

endmodule

// File: rtl/snake_body_ctrl.sv
// Per-tick sequencer for the snake body FIFO: seed, move, self-collision scan,
// push head / pop tail. Outputs decode the current state (Moore style).
module snake_body_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = 80,
   parameter int GRID_H   = 60,
   parameter int INIT_X   = 40,
   parameter int INIT_Y   = 30,
   parameter int INIT_LEN = 4,
   parameter int MAX_LEN  = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [1:0]         dir,
   input  logic [COORD_W-1:0] food_pos,
   input  logic [COORD_W-1:0] fifo_dout,
   input  logic               fifo_full,
   input  logic               fifo_empty,
   output logic               fifo_wr_en,
   output logic               fifo_rd_en,
   output logic [COORD_W-1:0] fifo_din,
   output logic [COORD_W-1:0] head_pos,
   output logic [COORD_W-1:0] tail_pos,
   output logic               tail_valid,
   output logic               step_done,
   output logic               ate,
   output logic               game_over,
   output logic [COORD_W-1:0] length,
   output logic               busy
);

   localparam int CNT_W = X_W + 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
   logic [COORD_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [COORD_W-1:0] length_q, length_d;
   logic [COORD_W-1:0] head_q, head_d;
   logic [COORD_W-1:0] tail_q, tail_d;
   logic [COORD_W-1:0] next_q, next_d;
   logic [1:0]         heading_q, heading_d;
   logic               grow_q, grow_d;
   logic               hit_q, hit_d;

   logic [COORD_W-1:0] nh_next;
   logic               nh_wall;
   logic [X_W-1:0]     init_x;

   // The flags are never consulted: the sequencing guarantees no over/underflow.
   logic unused_fifo_flags;
   assign unused_fifo_flags = fifo_full ^ fifo_empty;

   snake_next_head #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_next_head (
      .head_i     (head_q),
      .heading_i  (heading_q),
      .next_o     (nh_next),
      .wall_hit_o (nh_wall)
   );

   // init_cnt_q = k pushes segment k-1, so entry x = INIT_X-INIT_LEN+k.
   assign init_x = X_W'(INIT_X - INIT_LEN + int'(init_cnt_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         scan_cnt_q <= '0;
         length_q   <= '0;
         head_q     <= coord_pack(X_W'(INIT_X), Y_W'(INIT_Y));
         tail_q     <= '0;
         next_q     <= '0;
         heading_q  <= DIR_RIGHT;
         grow_q     <= 1'b0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         length_q   <= length_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         next_q     <= next_d;
         heading_q  <= heading_d;
         grow_q     <= grow_d;
         hit_q      <= hit_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      scan_cnt_d = scan_cnt_q;
      length_d   = length_q;
      head_d     = head_q;
      tail_d     = tail_q;
      next_d     = next_q;
      heading_d  = heading_q;
      grow_d     = grow_q;
      hit_d      = hit_q;
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
      fifo_din   = '0;
      tail_valid = 1'b0;
      step_done  = 1'b0;
      ate        = 1'b0;

      unique case (state_q)
         INIT: begin
            // First cycle after reset is quiet so the outputs hold their reset values.
            if (init_cnt_q != '0) begin
               fifo_wr_en = 1'b1;
               fifo_din   = coord_pack(init_x, Y_W'(INIT_Y));
            end
            if (init_cnt_q == CNT_W'(INIT_LEN)) begin
               length_d = COORD_W'(INIT_LEN);
               state_d  = IDLE;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (tick) begin
               if (dir != (heading_q ^ 2'b10)) begin
                  heading_d = dir;
               end
               state_d = CALC;
            end
         end
         CALC: begin
            next_d = nh_next;
            if (nh_wall) begin
               state_d = DEAD;
            end else begin
               grow_d     = (nh_next == food_pos) && (length_q < COORD_W'(MAX_LEN));
               hit_d      = 1'b0;
               scan_cnt_d = '0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            // Read leads write by one cycle; the FIFO occupancy stays constant.
            fifo_rd_en = (scan_cnt_q < length_q);
            if (scan_cnt_q != '0) begin
               fifo_wr_en = 1'b1;
               fifo_din   = fifo_dout;
               if (fifo_dout == next_q) begin
                  hit_d = 1'b1;
               end
            end
            if (scan_cnt_q == length_q) begin
               state_d = MOVE;
            end else begin
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end
         MOVE: begin
            if (hit_q) begin
               state_d = DEAD;
            end else begin
               fifo_wr_en = 1'b1;
               fifo_din   = next_q;
               head_d     = next_q;
               if (grow_q) begin
                  length_d = length_q + 1'b1;
               end else begin
                  fifo_rd_en = 1'b1;
               end
               state_d = POP;
            end
         end
         POP: begin
            if (!grow_q) begin
               tail_d = fifo_dout;
            end
            state_d = DONE;
         end
         DONE: begin
            step_done  = 1'b1;
            tail_valid = !grow_q;
            ate        = grow_q;
            state_d    = IDLE;
         end
         DEAD: begin
            state_d = DEAD;
         end
         default: begin
            state_d = DEAD;
         end
      endcase
   end

   assign head_pos  = head_q;
   assign tail_pos  = tail_q;
   assign length    = length_q;
   assign game_over = (state_q == DEAD);
   assign busy      = (state_q != IDLE) && (state_q != DEAD);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: queue-based FIFO model, write scoreboard and a
// high-level snake model that predicts every step.
module tb_snake_body_ctrl;

   localparam int GRID_W   = 80;
   localparam int GRID_H   = 60;
   localparam int INIT_X   = 40;
   localparam int INIT_Y   = 30;
   localparam int INIT_LEN = 4;
   localparam int MAX_LEN  = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic [1:0]  dir = 2'b00;
   logic [13:0] food_pos = '0;
   logic [13:0] fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_wr_en;
   logic        fifo_rd_en;
   logic [13:0] fifo_din;
   logic [13:0] head_pos;
   logic [13:0] tail_pos;
   logic        tail_valid;
   logic        step_done;
   logic        ate;
   logic        game_over;
   logic [13:0] length;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [13:0] exp_wr[$];
   logic [13:0] fifo_mem[$];
   int          fifo_cnt;
   logic [13:0] m_body[$];
   logic [13:0] m_head;
   logic [1:0]  m_heading;
   logic [13:0] mon_exp;

   always #5 clk = ~clk;

   snake_body_ctrl #(
      .GRID_W   (GRID_W),
      .GRID_H   (GRID_H),
      .INIT_X   (INIT_X),
      .INIT_Y   (INIT_Y),
      .INIT_LEN (INIT_LEN),
      .MAX_LEN  (MAX_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .dir        (dir),
      .food_pos   (food_pos),
      .fifo_dout  (fifo_dout),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_wr_en (fifo_wr_en),
      .fifo_rd_en (fifo_rd_en),
      .fifo_din   (fifo_din),
      .head_pos   (head_pos),
      .tail_pos   (tail_pos),
      .tail_valid (tail_valid),
      .step_done  (step_done),
      .ate        (ate),
      .game_over  (game_over),
      .length     (length),
      .busy       (busy)
   );

   // Body FIFO model: registered read data, reset by the same active-low rst.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_mem.delete();
         fifo_dout <= '0;
         fifo_cnt  <= 0;
      end else begin
         if (fifo_rd_en && fifo_mem.size() > 0) fifo_dout <= fifo_mem.pop_front();
         if (fifo_wr_en) fifo_mem.push_back(fifo_din);
         fifo_cnt <= fifo_mem.size();
      end
   end
   assign fifo_empty = (fifo_cnt == 0);
   assign fifo_full  = (fifo_cnt >= 8192);

   // Write scoreboard and access-legality monitor.
   always @(negedge clk) begin
      if (rst) begin
         if ((fifo_wr_en && fifo_full) || (fifo_rd_en && fifo_empty)) begin
            n_fail++;
            $display("FAIL fifo_flags: wr=%0b rd=%0b full=%0b empty=%0b, required no access on a flagged FIFO",
                     fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty);
         end
         if (game_over && (fifo_wr_en || fifo_rd_en)) begin
            n_fail++;
            $display("FAIL dead_access: wr=%0b rd=%0b, required 0 0 after game over", fifo_wr_en, fifo_rd_en);
         end
         if (fifo_wr_en) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL fifo_write: got unexpected push %h, required no push", fifo_din);
            end else begin
               mon_exp = exp_wr.pop_front();
               if (fifo_din !== mon_exp) begin
                  n_fail++;
                  $display("FAIL fifo_write: got %h, required %h", fifo_din, mon_exp);
               end
            end
         end
      end
   end

   function automatic logic [13:0] pk(input int x, input int y);
      logic [6:0] xs;
      logic [6:0] ys;
      xs = 7'(x);
      ys = 7'(y);
      return {xs, ys};
   endfunction

   task automatic seed_model();
      logic [13:0] c;
      m_body.delete();
      exp_wr.delete();
      for (int i = 0; i < INIT_LEN; i++) begin
         c = pk(INIT_X - INIT_LEN + 1 + i, INIT_Y);
         m_body.push_back(c);
         exp_wr.push_back(c);
      end
      m_head    = pk(INIT_X, INIT_Y);
      m_heading = 2'b01;
   endtask

   task automatic release_and_seed(input string tag);
      int last_wr;
      int busy_low;
      int nwr;
      seed_model();
      @(posedge clk);
      #2 rst = 1'b1;
      last_wr  = -1;
      busy_low = -1;
      nwr      = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fifo_wr_en) begin
            last_wr = i;
            nwr++;
         end
         if (!busy) begin
            busy_low = i;
            break;
         end
      end
      n_checks++;
      if (busy_low < 0 || busy_low != last_wr + 1) begin
         n_fail++;
         $display("FAIL %s busy_fall: got busy low at cycle %0d, required %0d", tag, busy_low, last_wr + 1);
      end
      n_checks++;
      if (nwr != INIT_LEN) begin
         n_fail++;
         $display("FAIL %s seed_count: got %0d pushes, required %0d", tag, nwr, INIT_LEN);
      end
      n_checks++;
      if (length !== 14'(INIT_LEN)) begin
         n_fail++;
         $display("FAIL %s seed_length: got %0d, required %0d", tag, length, INIT_LEN);
      end
      n_checks++;
      if (head_pos !== 14'h141E) begin
         n_fail++;
         $display("FAIL %s seed_head: got %h, required 141e", tag, head_pos);
      end
      n_checks++;
      if (exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL %s seed_pending: got %0d pushes missing, required 0", tag, exp_wr.size());
      end
      $display("%s: seeded %0d entries, head=%h len=%0d", tag, nwr, head_pos, length);
   endtask

   task automatic check_reset_values(input string tag);
      n_checks++;
      if ({fifo_wr_en, fifo_rd_en, tail_valid, step_done, ate, game_over, busy} !== 7'b0000001) begin
         n_fail++;
         $display("FAIL %s reset_flags: got wr=%0b rd=%0b tv=%0b sd=%0b ate=%0b go=%0b busy=%0b, required 0 0 0 0 0 0 1",
                  tag, fifo_wr_en, fifo_rd_en, tail_valid, step_done, ate, game_over, busy);
      end
      n_checks++;
      if ({fifo_din, head_pos, tail_pos, length} !== {14'h0, 14'h141E, 14'h0, 14'h0}) begin
         n_fail++;
         $display("FAIL %s reset_values: got din=%h head=%h tail=%h len=%0d, required 0000 141e 0000 0",
                  tag, fifo_din, head_pos, tail_pos, length);
      end
      $display("%s: reset values observed", tag);
   endtask

   task automatic do_step(input logic [1:0] d, input logic [13:0] food, input string tag);
      logic [13:0] nxt;
      logic [13:0] exp_tail;
      logic        wall;
      logic        hit;
      logic        grow;
      int          x;
      int          y;
      int          len0;
      int          n;
      bit          got;
      len0 = m_body.size();
      if (d != (m_heading ^ 2'b10)) m_heading = d;
      x = int'(m_head[13:7]);
      y = int'(m_head[6:0]);
      case (m_heading)
         2'b00: begin wall = (y == 0);          y = y - 1; end
         2'b01: begin wall = (x == GRID_W - 1); x = x + 1; end
         2'b10: begin wall = (y == GRID_H - 1); y = y + 1; end
         default: begin wall = (x == 0);        x = x - 1; end
      endcase
      nxt      = pk(x, y);
      hit      = 1'b0;
      grow     = 1'b0;
      exp_tail = '0;
      if (!wall) begin
         foreach (m_body[i]) begin
            exp_wr.push_back(m_body[i]);
            if (m_body[i] == nxt) hit = 1'b1;
         end
         if (!hit) begin
            exp_wr.push_back(nxt);
            grow = (nxt == food) && (len0 < MAX_LEN);
            m_body.push_back(nxt);
            if (!grow) exp_tail = m_body.pop_front();
         end
      end

      @(posedge clk);
      #1;
      tick     = 1'b1;
      dir      = d;
      food_pos = food;
      @(posedge clk);
      #1 tick = 1'b0;
      got = 0;
      n   = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (step_done || game_over) begin
            got = 1;
            break;
         end
         n++;
      end

      if (wall || hit) begin
         n_checks++;
         if (!got || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL %s game_over: got %0b, required 1", tag, game_over);
         end
         n_checks++;
         if (head_pos !== m_head) begin
            n_fail++;
            $display("FAIL %s dead_head: got %h, required %h", tag, head_pos, m_head);
         end
         n_checks++;
         if (n != (wall ? 1 : len0 + 3)) begin
            n_fail++;
            $display("FAIL %s dead_latency: got %0d, required %0d", tag, n, wall ? 1 : len0 + 3);
         end
      end else begin
         m_head = nxt;
         n_checks++;
         if (!got || step_done !== 1'b1 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL %s step_done: got sd=%0b go=%0b, required 1 0", tag, step_done, game_over);
         end
         n_checks++;
         if (n + 1 != len0 + 5) begin
            n_fail++;
            $display("FAIL %s latency: got T+%0d, required T+%0d", tag, n + 1, len0 + 5);
         end
         n_checks++;
         if (head_pos !== nxt || length !== 14'(m_body.size())) begin
            n_fail++;
            $display("FAIL %s head_len: got %h/%0d, required %h/%0d", tag, head_pos, length, nxt, m_body.size());
         end
         n_checks++;
         if (ate !== grow || tail_valid !== !grow) begin
            n_fail++;
            $display("FAIL %s ate_tv: got ate=%0b tv=%0b, required %0b %0b", tag, ate, tail_valid, grow, !grow);
         end
         if (!grow) begin
            n_checks++;
            if (tail_pos !== exp_tail) begin
               n_fail++;
               $display("FAIL %s tail_pos: got %h, required %h", tag, tail_pos, exp_tail);
            end
         end
      end
      n_checks++;
      if (exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL %s pushes_pending: got %0d missing, required 0", tag, exp_wr.size());
      end
      $display("%s: dir=%0d head=%h tail=%h len=%0d ate=%0b go=%0b", tag, d, head_pos, tail_pos, length, ate, game_over);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_reset_values("test_reset");
      release_and_seed("test_reset");
   endtask

   task automatic test_step();
      do_step(2'b01, 14'h0000, "test_step");
      n_checks++;
      if (head_pos !== 14'h149E || tail_pos !== 14'h129E) begin
         n_fail++;
         $display("FAIL test_step const: got head=%h tail=%h, required 149e 129e", head_pos, tail_pos);
      end
   endtask

   task automatic test_grow();
      do_step(2'b01, 14'h151E, "test_grow");
      n_checks++;
      if (head_pos !== 14'h151E || length !== 14'd5 || ate !== 1'b1) begin
         n_fail++;
         $display("FAIL test_grow const: got head=%h len=%0d ate=%0b, required 151e 5 1", head_pos, length, ate);
      end
   endtask

   task automatic test_reverse();
      do_step(2'b11, 14'h0000, "test_reverse");
      n_checks++;
      if (head_pos !== pk(43, 30)) begin
         n_fail++;
         $display("FAIL test_reverse const: got %h, required %h", head_pos, pk(43, 30));
      end
   endtask

   task automatic test_wall();
      bit seen_done;
      for (int i = 0; i < 30; i++) do_step(2'b00, 14'h0000, "test_wall_up");
      n_checks++;
      if (head_pos !== pk(43, 0)) begin
         n_fail++;
         $display("FAIL test_wall top_row: got %h, required %h", head_pos, pk(43, 0));
      end
      do_step(2'b00, 14'h0000, "test_wall_hit");
      @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (step_done || busy) seen_done = 1;
      end
      n_checks++;
      if (seen_done || game_over !== 1'b1 || head_pos !== pk(43, 0)) begin
         n_fail++;
         $display("FAIL test_wall ignored_tick: got activity=%0b go=%0b head=%h, required 0 1 %h",
                  seen_done, game_over, head_pos, pk(43, 0));
      end
      $display("test_wall: tick after game over ignored, go=%0b", game_over);
   endtask

   task automatic test_reset_mid_scan();
      bit in_scan;
      rst = 1'b0;
      #3;
      exp_wr.delete();
      release_and_seed("test_reset_pre");
      foreach (m_body[i]) exp_wr.push_back(m_body[i]);
      @(posedge clk);
      #1 tick = 1'b1;
      dir = 2'b01;
      @(posedge clk);
      #1 tick = 1'b0;
      in_scan = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_rd_en && fifo_wr_en) begin
            in_scan = 1;
            break;
         end
      end
      n_checks++;
      if (!in_scan) begin
         n_fail++;
         $display("FAIL test_reset_mid_scan reach_scan: got no overlapped read/write, required SCAN");
      end
      #2 rst = 1'b0;
      #1;
      exp_wr.delete();
      check_reset_values("test_reset_mid_scan");
      release_and_seed("test_reset_mid_scan");
   endtask

   task automatic test_self_collision();
      do_step(2'b01, pk(41, 30), "test_self_grow");
      do_step(2'b10, 14'h0000, "test_self_down");
      do_step(2'b11, 14'h0000, "test_self_left");
      do_step(2'b00, 14'h0000, "test_self_up");
      n_checks++;
      if (game_over !== 1'b1 || head_pos !== pk(40, 31)) begin
         n_fail++;
         $display("FAIL test_self_collision const: got go=%0b head=%h, required 1 %h", game_over, head_pos, pk(40, 31));
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_grow();
      test_reverse();
      test_wall();
      test_reset_mid_scan();
      test_self_collision();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
- Sequences the snake-body FIFO (14-bit {x,y} coordinates, depth 8192) once per game tick.
- Seeds the initial body, computes the new head from the direction input and checks wall collision.
- Checks self-collision by rotating the whole queue through the FIFO ports, then pushes the new head and pops the tail (or grows on food).
- Sits between the game-tick/keyboard logic and the body FIFO; reports head/tail moves to the VGA drawing logic.

Parameters:
GRID_W, 80, grid columns; x in 0..GRID_W-1
GRID_H, 60, grid rows; y in 0..GRID_H-1
INIT_X, 40, initial head x
INIT_Y, 30, initial head y
INIT_LEN, 4, initial segment count (>=1, <=INIT_X+1)
MAX_LEN, 1024, length cap (<=8192); food at cap does not grow

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
tick  in  1  one-cycle step request
dir  in  2  requested heading: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
food_pos  in  14  food coordinate {x[13:7], y[6:0]}
fifo_dout  in  14  FIFO registered read data
fifo_full  in  1  FIFO full
fifo_empty  in  1  FIFO empty
fifo_wr_en  out  1  FIFO push
fifo_rd_en  out  1  FIFO pop
fifo_din  out  14  FIFO write data
head_pos  out  14  current head coordinate
tail_pos  out  14  coordinate vacated by the last step
tail_valid  out  1  one-cycle pulse: tail_pos must be erased
step_done  out  1  one-cycle pulse: step complete
ate  out  1  one-cycle pulse with step_done when food was eaten
game_over  out  1  sticky collision flag
length  out  14  current segment count
busy  out  1  high in every state except IDLE and DEAD

Behaviour:
- Coordinates: {x,y}, each field 7 bits; value = x*128 + y.
- Reset values (async, rst low):
  - State INIT.
  - fifo_wr_en, fifo_rd_en = 0; fifo_din = 0.
  - head_pos = {INIT_X, INIT_Y}; tail_pos = 0; length = 0.
  - tail_valid, step_done, ate, game_over = 0.
  - busy = 1; heading = right; grow/hit flags cleared.
- The FIFO is reset by the same rst (inverted at top level).
- INIT: push INIT_LEN entries, tail first: (INIT_X-INIT_LEN+1+i, INIT_Y) for i = 0..INIT_LEN-1, one per cycle. length = INIT_LEN, then go to IDLE.
- IDLE: on tick, latch dir into heading unless it is the exact reverse of the current heading (reverse is ignored). Go to CALC. A tick in any other state is dropped.
- CALC (1 cycle): compute next head.
  - Wall collision (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down): go to DEAD. No FIFO access.
  - Otherwise set grow = (next == food_pos) && (length < MAX_LEN). Go to SCAN.
- SCAN: rotate the queue.
  - Assert fifo_rd_en for exactly `length` consecutive cycles.
  - Each cycle after a read, push fifo_dout back (fifo_wr_en = 1) and compare it with next head; on equality set hit.
  - Reads and writes overlap (FIFO count is constant). SCAN lasts length+1 cycles; all entries, including the tail, are compared.
- MOVE (1 cycle):
  - If hit: go to DEAD with no push.
  - Otherwise push next head and set head_pos = next.
  - If !grow: also assert fifo_rd_en (pops the tail, which is at the front again after the full rotation).
  - If grow: length += 1.
- POP (1 cycle): if !grow, register tail_pos = fifo_dout.
- DONE (1 cycle): step_done = 1, tail_valid = !grow, ate = grow. Return to IDLE.
- Latency: a tick sampled in cycle T gives step_done in cycle T+length+5 (length before the step).
- DEAD: game_over = 1; FIFO never touched; ticks ignored. Exit only via rst.
- fifo_full or fifo_empty seen asserted while the controller is pushing or popping is a design error. Never issue an access that relies on it; a bench assertion checks this.
- Reset mid-operation (any state): immediate return to reset values and INIT re-runs; the FIFO is cleared by the same reset.

Decomposition:
- Package snake_pkg:
  - COORD_W=14, X_W=7, Y_W=7
  - dir encodings DIR_UP/RIGHT/DOWN/LEFT
  - state enum INIT, IDLE, CALC, SCAN, MOVE, POP, DONE, DEAD
  - coord pack/unpack helpers
- One combinational sub-module, snake_next_head:
  - inputs: head, heading, GRID_W/H
  - outputs: next coord, wall_hit
- FSM, scan counter and length counter stay in snake_body_ctrl.

Test Plan:
- Reset release, defaults → four pushes: 0x129E, 0x131E, 0x139E, 0x141E; length=4; head_pos=0x141E; busy falls in the cycle after the last push.
- tick, dir=01, food_pos=0 → 4 rotation writes in the same order; step_done at T+9; head_pos=0x149E; tail_pos=0x129E; tail_valid=1; ate=0; length=4.
- food_pos=0x151E, tick, dir=01 → ate=1, tail_valid=0, length=5, head_pos=0x151E, no pop in MOVE.
- From heading right, dir=11 (reverse) + tick → ignored; head moves to x+1.
- 30 ticks with dir=00 from y=30 → y=0; next tick → game_over=1, no fifo_wr_en; further ticks ignored.
- Self-collision: length 5, then dir sequence down, left, up → hit detected in SCAN, game_over=1, head_pos unchanged.
- rst pulled low mid-SCAN → all outputs take reset values asynchronously; after release, INIT re-seeds identically to the first scenario.
